// File: rtl/regfile_writeback.sv
// Write-port arbiter for the integer register file: merges ALU results with a FIFO of
// long-latency results and tracks pending long-latency destinations for hazard checks.
module regfile_writeback #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ext_valid,
  output logic        ext_ready,
  input  logic [4:0]  ext_rd,
  input  logic [31:0] ext_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        stall_req,
  output logic        RegWEn,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  // Long-latency result FIFO storage
  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          regwen_q, regwen_d;
  logic [4:0]    rd_addr_q, rd_addr_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic [SW-1:0] starve_q, starve_d;
  logic [SW:0]   starve_inc;
  logic          stall_q, stall_d;

  logic [31:1]   pend_q, pend_d;

  logic          fifo_empty;
  logic          push_hs;
  logic          push;
  logic          pop;
  logic          alu_cand;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  assign fifo_empty = (count_q == '0);
  assign ext_ready  = (count_q != CW'(DEPTH));
  assign push_hs    = ext_valid && ext_ready;
  // x0 results complete the handshake but are never stored
  assign push       = push_hs && (ext_rd != 5'd0);
  assign alu_cand   = alu_valid && (alu_rd != 5'd0);
  assign pop        = !alu_cand && !fifo_empty;
  assign head_rd    = fifo_rd_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];
  assign starve_inc = {1'b0, starve_q} + (SW + 1)'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    regwen_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (alu_cand) begin
      regwen_d  = 1'b1;
      rd_addr_d = alu_rd;
      rd_data_d = alu_data;
    end else if (pop) begin
      regwen_d  = 1'b1;
      rd_addr_d = head_rd;
      rd_data_d = head_data;
    end
  end

  // Stall is raised on the edge the counter would reach STARVE_MAX, so the head
  // loses exactly STARVE_MAX times before the pipeline yields a slot.
  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (alu_cand) begin
      if (starve_inc >= (SW + 1)'(STARVE_MAX)) begin
        stall_d  = 1'b1;
        starve_d = '0;
      end else begin
        starve_d = starve_inc[SW-1:0];
      end
    end
  end

  // Set has priority over the clear from a same-cycle FIFO write
  always_comb begin
    pend_d = pend_q;
    if (pop && (head_rd != 5'd0)) pend_d[head_rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) pend_d[issue_rd] = 1'b1;
  end

  assign rs1_busy = (rs1_addr != 5'd0) && pend_q[rs1_addr];
  assign rs2_busy = (rs2_addr != 5'd0) && pend_q[rs2_addr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= ext_rd;
      fifo_data_q[wr_ptr_q] <= ext_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      regwen_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      pend_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      regwen_q  <= regwen_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      pend_q    <= pend_d;
    end
  end

  assign RegWEn    = regwen_q;
  assign rd_addr   = rd_addr_q;
  assign rd_data   = rd_data_q;
  assign stall_req = stall_q;

endmodule
